// File: rtl/video_timing_gen.sv
// Raster timing source: pixel/line counters with registered, zero-skew sync and position outputs.
// Optional frame counter output is enabled by defining VIDEO_TIMING_FRAME_COUNT_EN.
module video_timing_gen #(
  parameter int H_DISPLAY = 256,
  parameter int H_FRONT   = 7,
  parameter int H_SYNC    = 23,
  parameter int H_BACK    = 23,
  parameter int V_DISPLAY = 240,
  parameter int V_BOTTOM  = 14,
  parameter int V_SYNC    = 3,
  parameter int V_TOP     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [8:0] hpos,
  output logic [8:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  // Counters are 9 bits wide; a raster that does not fit must not build.
  generate
    if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_total_too_large
      $error("video_timing_gen: H_TOTAL or V_TOTAL exceeds 512");
    end
  endgenerate

  localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC);

  function automatic logic in_range(input logic [8:0] p,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi_excl);
    return ({1'b0, p} >= lo) && ({1'b0, p} < hi_excl);
  endfunction

  logic [8:0] h_nxt;
  logic [8:0] v_nxt;
  logic       h_wrap;
  logic       v_wrap;

  assign h_wrap = (hpos == H_LAST);
  assign v_wrap = (vpos == V_LAST);

  always_comb begin
    h_nxt = hpos + 9'd1;
    v_nxt = vpos;
    if (h_wrap) begin
      h_nxt = '0;
      v_nxt = v_wrap ? 9'd0 : vpos + 9'd1;
    end
  end

  // Every output is decoded from the next position so it lands on the same edge as hpos/vpos.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      display_on  <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else if (pix_en) begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      hsync       <= in_range(h_nxt, HS_START, HS_END);
      vsync       <= in_range(v_nxt, VS_START, VS_END);
      display_on  <= in_range(h_nxt, 10'd0, H_VIS) && in_range(v_nxt, 10'd0, V_VIS);
      line_start  <= (h_nxt == 9'd0);
      frame_start <= (h_nxt == 9'd0) && (v_nxt == 9'd0);
    end
  end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (pix_en && h_wrap && v_wrap) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: reset, one line walk, a full frame, stalls and mid-frame reset.
module tb_video_timing_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_start;
  logic       frame_start;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_count;
`endif

  int total = 0;
  int bad   = 0;

  video_timing_gen dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .hpos        (hpos),
    .vpos        (vpos),
    .hsync       (hsync),
    .vsync       (vsync),
    .display_on  (display_on),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges; outputs are sampled on the following falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  int n_per;
  int vs_cnt;
  int vs_rise_h;
  int vs_rise_v;
  int last_v;
  bit vs_seen;

  initial begin
    reset  = 1'b1;
    pix_en = 1'b1;
    step(3);
    check("rst_hpos", hpos, 0);
    check("rst_vpos", vpos, 0);
    check("rst_hsync", hsync, 0);
    check("rst_vsync", vsync, 0);
    check("rst_disp", display_on, 1);
    check("rst_line", line_start, 1);
    check("rst_frame", frame_start, 1);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    check("rst_fcnt", frame_count, 0);
`endif

    reset  = 1'b0;
    pix_en = 1'b0;
    step(1);
    check("rel_hold_hpos", hpos, 0);
    check("rel_hold_frame", frame_start, 1);

    // One line walk
    pix_en = 1'b1;
    step(1);
    check("h1_hpos", hpos, 1);
    check("h1_line", line_start, 0);
    check("h1_frame", frame_start, 0);
    step(254);
    check("h255_disp", display_on, 1);
    step(1);
    check("h256_hpos", hpos, 256);
    check("h256_disp", display_on, 0);
    step(6);
    check("h262_hsync", hsync, 0);
    step(1);
    check("h263_hpos", hpos, 263);
    check("h263_hsync", hsync, 1);
    step(22);
    check("h285_hsync", hsync, 1);
    step(1);
    check("h286_hsync", hsync, 0);
    step(22);
    check("h308_hpos", hpos, 308);
    check("h308_vpos", vpos, 0);
    step(1);
    check("wrap_hpos", hpos, 0);
    check("wrap_vpos", vpos, 1);
    check("wrap_line", line_start, 1);
    check("wrap_frame", frame_start, 0);
    check("wrap_disp", display_on, 1);

    // Rest of the frame, from (0,1) back to (0,0)
    n_per   = 0;
    vs_cnt  = 0;
    vs_seen = 1'b0;
    last_v  = vpos;
    vs_rise_h = -1;
    vs_rise_v = -1;
    while (!frame_start && n_per < 90000) begin
      last_v = vpos;
      step(1);
      n_per++;
      if (vsync) begin
        vs_cnt++;
        if (!vs_seen) begin
          vs_seen   = 1'b1;
          vs_rise_h = hpos;
          vs_rise_v = vpos;
        end
      end
    end
    check("frame_periods", n_per, 80958 - 309);
    check("vsync_len", vs_cnt, 927);
    check("vsync_rise_v", vs_rise_v, 254);
    check("vsync_rise_h", vs_rise_h, 0);
    check("vwrap_prev_v", last_v, 261);
    check("vwrap_vpos", vpos, 0);
    check("vwrap_hpos", hpos, 0);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    check("fcnt_one", frame_count, 1);
`endif

    // Stall at (0,0), then enable pattern 1,0,0,1
    pix_en = 1'b0;
    step(2);
    check("stall_hpos", hpos, 0);
    check("stall_line", line_start, 1);
    check("stall_frame", frame_start, 1);
    pix_en = 1'b1; step(1);
    check("pat1_hpos", hpos, 1);
    check("pat1_line", line_start, 0);
    pix_en = 1'b0; step(1);
    check("pat2_hpos", hpos, 1);
    step(1);
    check("pat3_hpos", hpos, 1);
    pix_en = 1'b1; step(1);
    check("pat4_hpos", hpos, 2);

    // Move into the hsync region of line 10, then reset while stalled
    step(10 * 309 + 268);
    check("pre_rst_hpos", hpos, 270);
    check("pre_rst_vpos", vpos, 10);
    check("pre_rst_hsync", hsync, 1);
    check("pre_rst_disp", display_on, 0);
    pix_en = 1'b0;
    reset  = 1'b1;
    step(1);
    check("mid_rst_hpos", hpos, 0);
    check("mid_rst_vpos", vpos, 0);
    check("mid_rst_hsync", hsync, 0);
    check("mid_rst_vsync", vsync, 0);
    check("mid_rst_disp", display_on, 1);
    check("mid_rst_line", line_start, 1);
    check("mid_rst_frame", frame_start, 1);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    check("mid_rst_fcnt", frame_count, 0);
`endif
    reset  = 1'b0;
    pix_en = 1'b1;
    step(1);
    check("resume_hpos", hpos, 1);
    check("resume_vpos", vpos, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
